// File: rtl/surf_id_ctrl_pkg.sv
// rtl/surf_id_ctrl_pkg.sv - register map constants and byte-merge helper for surf_id_ctrl
// Purpose: shared word offsets (wb_adr_i[7:2]) and the byte-lane write merge
//          used by every byte-selectable register in surf_id_ctrl.
// Ports:   none (package).
package surf_id_ctrl_pkg;

  localparam logic [5:0] ADDR_IDENT        = 6'd0;
  localparam logic [5:0] ADDR_DATEVERSION  = 6'd1;
  localparam logic [5:0] ADDR_CONTROL      = 6'd2;
  localparam logic [5:0] ADDR_PULSE        = 6'd3;
  localparam logic [5:0] ADDR_STATUS       = 6'd4;
  localparam logic [5:0] ADDR_UPTIME       = 6'd5;
  localparam logic [5:0] ADDR_SCRATCH_BASE = 6'd8;

  // PULSE bit that also clears the uptime counter and its prescaler
  localparam int PULSE_UPTIME_CLR = 0;

  // Replace each byte of old_w whose select bit is set with the same byte of new_w.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/surf_uptime_ctr.sv
// rtl/surf_uptime_ctr.sv - prescaled seconds counter for surf_id_ctrl
// Purpose: prescaler runs 0..PRESCALE-1; on terminal count it returns to 0 and
//          count increments (wrapping at 32 bits). clr zeroes both and takes
//          priority over a coincident increment.
// Ports:   clk, rst_n (async active-low), clr (synchronous clear), count[31:0].
module surf_uptime_ctr #(
  parameter int PRESCALE = 62500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  output logic [31:0] count
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      count <= 32'h0;
    end else if (clr) begin
      presc <= '0;
      count <= 32'h0;
    end else if (presc == PW'(PRESCALE - 1)) begin
      presc <= '0;
      count <= count + 32'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/surf_id_ctrl.sv
// rtl/surf_id_ctrl.sv - SURF identity/control/status WISHBONE classic register slave
// Purpose: single-cycle-latency register file on the regclk bus: IDENT, DATEVERSION,
//          CONTROL (RW), PULSE (WO strobes), STATUS (synchronized), UPTIME and
//          NUM_SCRATCH scratch words.
// Ports:   wb_clk_i, wb_rst_n_i (async active-low), wb_cyc_i/wb_stb_i/wb_we_i/
//          wb_adr_i/wb_dat_i/wb_sel_i (request), wb_dat_o/wb_ack_o/wb_err_o
//          (termination), ctrl_o (CONTROL), pulse_o (one-cycle strobes),
//          status_i (asynchronous status inputs).
// Build option: SURF_ID_CTRL_ERR_EN - unmapped accesses and writes to read-only
//          registers terminate with wb_err_o instead of wb_ack_o.
module surf_id_ctrl
  import surf_id_ctrl_pkg::*;
#(
  parameter logic [31:0] IDENT        = 32'h53555246,
  parameter logic [31:0] DATEVERSION  = 32'h0,
  parameter int          ADDR_BITS    = 22,
  parameter int          NUM_SCRATCH  = 4,
  parameter logic [31:0] CTRL_RESET   = 32'h0,
  parameter int          STATUS_WIDTH = 16,
  parameter int          PRESCALE     = 62500000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_BITS-1:0]    wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  input  logic [3:0]              wb_sel_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [31:0]             ctrl_o,
  output logic [31:0]             pulse_o,
  input  logic [STATUS_WIDTH-1:0] status_i
);

  logic                    req;
  logic                    bad;
  logic                    mapped;
  logic                    ro;
  logic                    scr_hit;
  logic                    wr_en;
  logic                    uptime_clr;
  logic                    adr_unused;
  logic [5:0]              word;
  logic [31:0]             rd_data;
  logic [31:0]             uptime;
  logic [STATUS_WIDTH-1:0] status_meta;
  logic [STATUS_WIDTH-1:0] status_sync;
  // Sized for the maximum of 8; entries at or above NUM_SCRATCH are never
  // written or read and stay at their reset value.
  logic [31:0]             scratch [8];

  // A termination in flight blocks a new request, so a held stb is served every other cycle.
  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign word       = wb_adr_i[7:2];
  assign adr_unused = ^wb_adr_i[1:0];

  always_comb begin
    rd_data = 32'h0;
    mapped  = 1'b0;
    ro      = 1'b0;
    scr_hit = 1'b0;
    if (~|wb_adr_i[ADDR_BITS-1:8]) begin
      case (word)
        ADDR_IDENT:       begin rd_data = IDENT;               mapped = 1'b1; ro = 1'b1; end
        ADDR_DATEVERSION: begin rd_data = DATEVERSION;         mapped = 1'b1; ro = 1'b1; end
        ADDR_CONTROL:     begin rd_data = ctrl_o;              mapped = 1'b1; end
        ADDR_PULSE:       begin                                mapped = 1'b1; end
        ADDR_STATUS:      begin rd_data = 32'(status_sync);    mapped = 1'b1; ro = 1'b1; end
        ADDR_UPTIME:      begin rd_data = uptime;              mapped = 1'b1; ro = 1'b1; end
        default: begin
          if (word >= ADDR_SCRATCH_BASE && word < 6'(ADDR_SCRATCH_BASE + NUM_SCRATCH)) begin
            scr_hit = 1'b1;
            mapped  = 1'b1;
            rd_data = scratch[word[2:0]];
          end
        end
      endcase
    end
  end

`ifdef SURF_ID_CTRL_ERR_EN
  assign bad = ~mapped | (wb_we_i & ro);
`else
  assign bad = 1'b0;
`endif

  assign wr_en      = req & wb_we_i & mapped & ~ro & ~bad;
  assign uptime_clr = wr_en & (word == ADDR_PULSE) & wb_sel_i[0] & wb_dat_i[PULSE_UPTIME_CLR];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'h0;
      ctrl_o   <= CTRL_RESET;
      pulse_o  <= 32'h0;
      for (int i = 0; i < 8; i++) scratch[i] <= 32'h0;
    end else begin
      wb_ack_o <= req & ~bad;
      wb_err_o <= req & bad;
      wb_dat_o <= (req && !bad && !wb_we_i) ? rd_data : 32'h0;
      pulse_o  <= 32'h0;
      if (wr_en) begin
        if (word == ADDR_CONTROL) ctrl_o  <= byte_merge(ctrl_o, wb_dat_i, wb_sel_i);
        if (word == ADDR_PULSE)   pulse_o <= byte_merge(32'h0, wb_dat_i, wb_sel_i);
        if (scr_hit) scratch[word[2:0]] <= byte_merge(scratch[word[2:0]], wb_dat_i, wb_sel_i);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      status_meta <= '0;
      status_sync <= '0;
    end else begin
      status_meta <= status_i;
      status_sync <= status_meta;
    end
  end

  surf_uptime_ctr #(
    .PRESCALE(PRESCALE)
  ) u_uptime (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .clr   (uptime_clr),
    .count (uptime)
  );

endmodule

// File: tb/tb_surf_id_ctrl.sv
// tb/tb_surf_id_ctrl.sv - self-checking bench for surf_id_ctrl
module tb_surf_id_ctrl;

  localparam logic [31:0] DV = 32'h1A2B0401;
  localparam int          PS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [21:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [3:0]  wb_sel = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [31:0] ctrl_o;
  logic [31:0] pulse_o;
  logic [15:0] status = 16'h1234;

  int          n_checks = 0;
  int          n_errors = 0;
  int          edge_cnt = 0;
  int          clr_edge = 0;
  logic [31:0] sb_q [$];

  surf_id_ctrl #(
    .DATEVERSION (DV),
    .PRESCALE    (PS)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_cyc_i   (wb_cyc),
    .wb_stb_i   (wb_stb),
    .wb_we_i    (wb_we),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat),
    .wb_sel_i   (wb_sel),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .ctrl_o     (ctrl_o),
    .pulse_o    (pulse_o),
    .status_i   (status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One transfer with an idle cycle after it. Called and returns 1 ns after a rising edge.
  task automatic xfer(input string tag, input logic we, input logic [21:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] exp_rd);
    logic [31:0] exp_pulse;
    logic [31:0] exp;
    exp_pulse = 32'h0;
    if (we && adr[21:8] == 14'h0 && adr[7:2] == 6'd3) begin
      for (int b = 0; b < 4; b++) if (sel[b]) exp_pulse[8*b +: 8] = dat[8*b +: 8];
    end
    if (!we) sb_q.push_back(exp_rd);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    @(posedge clk); #1;
    check({tag, "/ack"}, 32'(wb_ack_o), 32'h1);
    check({tag, "/err"}, 32'(wb_err_o), 32'h0);
    check({tag, "/pulse"}, pulse_o, exp_pulse);
    if (wb_ack_o && !we) begin
      exp = sb_q.pop_front();
      check({tag, "/data"}, wb_dat_o, exp);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    check({tag, "/ack_once"}, 32'(wb_ack_o), 32'h0);
    check({tag, "/pulse_once"}, pulse_o, 32'h0);
  endtask

  initial begin
    logic [31:0] exp;

    // reset state
    idle(3);
    check("rst_ack", 32'(wb_ack_o), 32'h0);
    check("rst_err", 32'(wb_err_o), 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_ctrl", ctrl_o, 32'h0);
    check("rst_pulse", pulse_o, 32'h0);
    rst_n = 1'b1;
    idle(1);

    // identity
    xfer("ident", 1'b0, 22'h000, 32'h0, 4'hF, 32'h53555246);
    xfer("datever", 1'b0, 22'h004, 32'h0, 4'hF, 32'h1A2B0401);

    // control byte-selectable
    xfer("ctrl_wr", 1'b1, 22'h008, 32'hDEADBEEF, 4'b0101, 32'h0);
    check("ctrl_o", ctrl_o, 32'h00AD00EF);
    xfer("ctrl_rd", 1'b0, 22'h008, 32'h0, 4'hF, 32'h00AD00EF);

    // read-only write ignored
    xfer("ident_wr", 1'b1, 22'h000, 32'h0, 4'hF, 32'h0);
    xfer("ident_rd2", 1'b0, 22'h000, 32'h0, 4'hF, 32'h53555246);

    // scratch
    for (int i = 0; i < 4; i++)
      xfer("scr_wr", 1'b1, 22'(32'h20 + 4 * i), 32'h11111111 * (i + 1), 4'hF, 32'h0);
    xfer("scr1_byte", 1'b1, 22'h024, 32'hABCDEF01, 4'b1000, 32'h0);
    xfer("scr0_rd", 1'b0, 22'h020, 32'h0, 4'hF, 32'h11111111);
    xfer("scr1_rd", 1'b0, 22'h024, 32'h0, 4'hF, 32'hAB222222);
    xfer("scr3_rd", 1'b0, 22'h02C, 32'h0, 4'hF, 32'h44444444);

    // unmapped: ack with zero data, writes ignored
    xfer("unm_100", 1'b0, 22'h100, 32'h0, 4'hF, 32'h0);
    xfer("unm_scr4", 1'b0, 22'h030, 32'h0, 4'hF, 32'h0);
    xfer("unm_18", 1'b0, 22'h018, 32'h0, 4'hF, 32'h0);
    xfer("unm_scr4_wr", 1'b1, 22'h030, 32'hFFFFFFFF, 4'hF, 32'h0);
    xfer("unm_hi_wr", 1'b1, 22'h108, 32'hFFFFFFFF, 4'hF, 32'h0);
    check("ctrl_after_unm", ctrl_o, 32'h00AD00EF);
    xfer("scr3_rd2", 1'b0, 22'h02C, 32'h0, 4'hF, 32'h44444444);

    // held strobe: acks at N+1 and N+3 only
    sb_q.push_back(32'h53555246);
    sb_q.push_back(32'h53555246);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 22'h000; wb_sel = 4'hF;
    idle(1);
    check("held_ack1", 32'(wb_ack_o), 32'h1);
    if (wb_ack_o) begin exp = sb_q.pop_front(); check("held_dat1", wb_dat_o, exp); end
    idle(1);
    check("held_gap", 32'(wb_ack_o), 32'h0);
    idle(1);
    check("held_ack2", 32'(wb_ack_o), 32'h1);
    if (wb_ack_o) begin exp = sb_q.pop_front(); check("held_dat2", wb_dat_o, exp); end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    idle(1);
    check("held_end", 32'(wb_ack_o), 32'h0);

    // pulse + uptime clear, then count 40 cycles
    xfer("pulse_wr", 1'b1, 22'h00C, 32'h80000003, 4'hF, 32'h0);
    clr_edge = edge_cnt - 1;
    xfer("pulse_rd", 1'b0, 22'h00C, 32'h0, 4'hF, 32'h0);
    idle(clr_edge + 40 - edge_cnt);
    xfer("uptime10", 1'b0, 22'h014, 32'h0, 4'hF, 32'((edge_cnt - clr_edge) / PS));
    idle(1);
    xfer("uptime_inc_edge", 1'b0, 22'h014, 32'h0, 4'hF, 32'((edge_cnt - clr_edge) / PS));
    xfer("uptime_after", 1'b0, 22'h014, 32'h0, 4'hF, 32'((edge_cnt - clr_edge) / PS));

    // wrap
    xfer("clr_wr", 1'b1, 22'h00C, 32'h00000001, 4'b0001, 32'h0);
    clr_edge = edge_cnt - 1;
    force dut.u_uptime.count = 32'hFFFFFFFF;
    #1;
    release dut.u_uptime.count;
    xfer("uptime_max", 1'b0, 22'h014, 32'h0, 4'hF, 32'hFFFFFFFF);
    idle(1);
    xfer("uptime_wrap", 1'b0, 22'h014, 32'h0, 4'hF, 32'h0);

    // clear on the same edge as a tick
    while (((edge_cnt + 1 - clr_edge) % PS) != 0) idle(1);
    xfer("clr_on_tick", 1'b1, 22'h00C, 32'h00000001, 4'b0001, 32'h0);
    clr_edge = edge_cnt - 1;
    xfer("uptime_clr_win", 1'b0, 22'h014, 32'h0, 4'hF, 32'h0);

    // status synchronizer latency
    status = 16'h00A5;
    xfer("status_same", 1'b0, 22'h010, 32'h0, 4'hF, 32'h00001234);
    status = 16'h1234;
    idle(3);
    status = 16'h00A5;
    idle(2);
    xfer("status_3cyc", 1'b0, 22'h010, 32'h0, 4'hF, 32'h000000A5);

    // reset asserted during an ack
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 22'h00C; wb_dat = 32'h00000100; wb_sel = 4'hF;
    idle(1);
    check("mid_ack", 32'(wb_ack_o), 32'h1);
    check("mid_pulse", pulse_o, 32'h00000100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(wb_ack_o), 32'h0);
    check("mid_rst_pulse", pulse_o, 32'h0);
    check("mid_rst_ctrl", ctrl_o, 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    xfer("scr0_after_rst", 1'b0, 22'h020, 32'h0, 4'hF, 32'h0);
    xfer("ctrl_after_rst", 1'b0, 22'h008, 32'h0, 4'hF, 32'h0);

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
